// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU op codes, FSM states and
// the requester-ID width helper.
package alu_share_pkg;

    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, response and shared-ALU signals of the ALU-sharing arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_share_if
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [2*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic [1:0]                alu_op_code;
    logic [DATA_W-1:0]         alu_operand_a;
    logic [DATA_W-1:0]         alu_operand_b;
    logic [DATA_W-1:0]         alu_result;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, alu_op_code, alu_operand_a, alu_operand_b,
               rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, alu_op_code, alu_operand_a, alu_operand_b,
               rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from i_ptr+1 upwards with wrap.
// With i_prio0 high, requester 0 wins outright (used when ARB_PRIO_EN is defined).
module rr_arbiter
    import alu_share_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_prio0,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_id
);

    logic w_found;
    logic w_hit;
    int   w_idx;

    // Priority override first, then the first requester after the pointer.
    always_comb begin
        o_grant       = {N{1'b0}};
        o_grant_id    = {ID_W{1'b0}};
        w_hit         = 1'b0;
        w_idx         = 0;
        w_found       = i_prio0 & i_req[0];
        o_grant[0]    = w_found;
        for (int k = 1; k <= N; k++) begin
            w_idx            = (int'(i_ptr) + k) % N;
            w_hit            = !w_found && i_req[w_idx];
            o_grant[w_idx]   = o_grant[w_idx] | w_hit;
            o_grant_id       = w_hit ? w_idx[ID_W-1:0] : o_grant_id;
            w_found          = w_found | w_hit;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters (IDLE->EXEC->RESP).
// Define ARB_PRIO_EN to give requester 0 absolute priority over the round robin.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_share_if.slave bus
);
    localparam int ID_W = id_width(NUM_REQ);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_result;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_id;
    logic                w_accept;
    logic                w_rsp_done;
    logic                w_prio0;
    logic                w_ptr_upd;
    int                  w_sel;

`ifdef ARB_PRIO_EN
    // Grants to requester 0 leave the round-robin position untouched.
    assign w_prio0   = 1'b1;
    assign w_ptr_upd = (w_grant_id != {ID_W{1'b0}});
`else
    assign w_prio0   = 1'b0;
    assign w_ptr_upd = 1'b1;
`endif

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req      (bus.req_valid),
        .i_ptr      (r_ptr),
        .i_prio0    (w_prio0),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign w_sel = int'(w_grant_id);

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_rsp_done    = 1'b0;
        bus.req_ready = {NUM_REQ{1'b0}};
        case (r_state)
            IDLE: begin
                bus.req_ready = w_grant;
                w_accept      = |w_grant;
                w_state_nxt   = w_accept ? EXEC : IDLE;
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_done  = bus.rsp_ready;
                w_state_nxt = w_rsp_done ? IDLE : RESP;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture and round-robin pointer, updated only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= 2'b00;
            r_a   <= {DATA_W{1'b0}};
            r_b   <= {DATA_W{1'b0}};
            r_id  <= {ID_W{1'b0}};
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_op <= bus.req_op[2*w_sel +: 2];
            r_a  <= bus.req_a[DATA_W*w_sel +: DATA_W];
            r_b  <= bus.req_b[DATA_W*w_sel +: DATA_W];
            r_id <= w_grant_id;
            if (w_ptr_upd) begin
                r_ptr <= w_grant_id;
            end
        end
    end

    // Response register: loaded in EXEC, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= {ID_W{1'b0}};
            r_rsp_result <= {DATA_W{1'b0}};
        end else if (r_state == EXEC) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= bus.alu_result;
        end else if (w_rsp_done) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign bus.alu_op_code   = r_op;
    assign bus.alu_operand_a = r_a;
    assign bus.alu_operand_b = r_b;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_result    = r_rsp_result;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a cycle-level reference model;
// expected grant orders follow ARB_PRIO_EN when it is defined.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // Shared ALU stand-in
    always_comb bus.alu_result = alu_f(bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: winner given the valid vector and the last round-robin winner.
    function automatic int exp_winner(input logic [N-1:0] v, input int last);
`ifdef ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_id(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Model state and logs of observed DUT behaviour
    int          cyc = 0;
    bit          m_free = 1'b1;
    int          m_last = N - 1;
    int          m_acc = 0;
    int          m_exp_id = 0;
    logic [31:0] m_exp_res = 32'd0;
    logic [1:0]  m_op = 2'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    bit          p_rv = 1'b0;
    int          dut_acc = 0;
    int          grant_q[$];
    int          acc_q[$];
    int          rid_q[$];
    int          lat_q[$];
    logic [31:0] res_q[$];

    always @(negedge clk) begin
        int          w;
        logic [N-1:0] exp_rdy;
        bit          exp_rv;
        cyc++;
        if (!rst_n) begin
            m_free = 1'b1;
            m_last = N - 1;
            m_op = 2'd0; m_a = 32'd0; m_b = 32'd0;
            p_rv = 1'b0;
            check("rst_req_ready", 64'(bus.req_ready), 64'd0);
            check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
            check("rst_alu_a", 64'(bus.alu_operand_a), 64'd0);
        end else begin
            check("alu_op", 64'(bus.alu_op_code), 64'(m_op));
            check("alu_a", 64'(bus.alu_operand_a), 64'(m_a));
            check("alu_b", 64'(bus.alu_operand_b), 64'(m_b));
            if (bus.req_ready != '0) begin
                grant_q.push_back(onehot_id(bus.req_ready));
                acc_q.push_back(cyc);
                dut_acc = cyc;
            end
            if (bus.rsp_valid && !p_rv) lat_q.push_back(cyc - dut_acc);
            if (bus.rsp_valid && bus.rsp_ready) begin
                res_q.push_back(bus.rsp_result);
                rid_q.push_back(int'(bus.rsp_id));
            end
            p_rv = bus.rsp_valid;
            if (m_free) begin
                w = exp_winner(bus.req_valid, m_last);
                exp_rdy = '0;
                if (w >= 0) exp_rdy[w] = 1'b1;
                check("req_ready_idle", 64'(bus.req_ready), 64'(exp_rdy));
                check("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
                if (w >= 0) begin
                    m_free    = 1'b0;
                    m_acc     = cyc;
                    m_exp_id  = w;
                    m_op      = bus.req_op[2*w +: 2];
                    m_a       = bus.req_a[32*w +: 32];
                    m_b       = bus.req_b[32*w +: 32];
                    m_exp_res = alu_f(m_op, m_a, m_b);
`ifdef ARB_PRIO_EN
                    if (w != 0) m_last = w;
`else
                    m_last = w;
`endif
                end
            end else begin
                check("req_ready_busy", 64'(bus.req_ready), 64'd0);
                exp_rv = (cyc - m_acc) >= 2;
                check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
                if (exp_rv) begin
                    check("rsp_id", 64'(bus.rsp_id), 64'(m_exp_id));
                    check("rsp_result", 64'(bus.rsp_result), 64'(m_exp_res));
                    if (bus.rsp_ready) m_free = 1'b1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]     = v;
        bus.req_op[2*i +: 2] = op;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic run_op(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        set_req(i, 1'b1, op, a, b);
        step(1);
        bus.req_valid[i] = 1'b0;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nres;
        int exp4[5];
        int exp6[4];
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        step(3);
        check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst_n = 1'b1;

        // Single add
        run_op(1, ADD, 32'd5, 32'd7);
        check("t2_grant", 64'(grant_q[$]), 64'd1);
        check("t2_result", 64'(res_q[$]), 64'd12);
        check("t2_id", 64'(rid_q[$]), 64'd1);
        check("t2_latency", 64'(lat_q[$]), 64'd2);

        // Wrap-around and logic ops
        run_op(2, SUB, 32'd0, 32'd1);
        check("t3_sub_wrap", 64'(res_q[$]), 64'hFFFF_FFFF);
        run_op(2, OR, 32'h0000_00F0, 32'h0000_000F);
        check("t3_or", 64'(res_q[$]), 64'h0000_00FF);
        run_op(3, ADD, 32'hFFFF_FFFF, 32'd2);
        check("t3_add_wrap", 64'(res_q[$]), 64'd1);
        run_op(3, AND, 32'h0000_F0F0, 32'h0000_FF00);
        check("t3_and", 64'(res_q[$]), 64'h0000_F000);
        check("t3_id", 64'(rid_q[$]), 64'd3);

        // All requesters valid continuously
        base = grant_q.size();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'(i), 32'(100 * (i + 1)), 32'(i + 3));
        step(13);
        bus.req_valid = '0;
        step(2);
`ifdef ARB_PRIO_EN
        exp4 = '{0, 0, 0, 0, 0};
`else
        exp4 = '{0, 1, 2, 3, 0};
`endif
        check("t4_count", 64'(grant_q.size() - base), 64'd5);
        for (int k = 0; k < 5; k++) check($sformatf("t4_grant%0d", k), 64'(grant_q[base + k]), 64'(exp4[k]));

        // Backpressure for 5 cycles in RESP
        set_req(1, 1'b1, SUB, 32'd50, 32'd8);
        set_req(2, 1'b1, ADD, 32'd1, 32'd1);
        step(1);
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready    = 1'b0;
        step(6);
        check("t5_held_valid", 64'(bus.rsp_valid), 64'd1);
        check("t5_held_result", 64'(bus.rsp_result), 64'd42);
        bus.rsp_ready = 1'b1;
        step(1);
        step(1);
        bus.req_valid[2] = 1'b0;
        step(2);
        check("t5_grant_a", 64'(grant_q[$-1]), 64'd1);
        check("t5_grant_b", 64'(grant_q[$]), 64'd2);
        check("t5_accept_gap", 64'(acc_q[$] - acc_q[$-1]), 64'd8);

        // Requesters 0 and 2 always valid
        base = grant_q.size();
        set_req(0, 1'b1, OR, 32'h10, 32'h01);
        set_req(2, 1'b1, SUB, 32'd9, 32'd4);
        step(10);
        bus.req_valid = '0;
        step(2);
`ifdef ARB_PRIO_EN
        exp6 = '{0, 0, 0, 0};
`else
        exp6 = '{0, 2, 0, 2};
`endif
        check("t6_count", 64'(grant_q.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t6_grant%0d", k), 64'(grant_q[base + k]), 64'(exp6[k]));

        // Reset while EXEC
        nres = res_q.size();
        run_op(3, ADD, 32'd1, 32'd2);
        nres = res_q.size();
        set_req(3, 1'b1, ADD, 32'd3, 32'd4);
        step(1);
        bus.req_valid[3] = 1'b0;
        rst_n = 1'b0;
        step(2);
        check("t1_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t1_rst_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        set_req(0, 1'b1, ADD, 32'd20, 32'd22);
        set_req(1, 1'b1, ADD, 32'd1, 32'd1);
        step(1);
        bus.req_valid = '0;
        step(2);
        check("t1_first_grant", 64'(grant_q[$]), 64'd0);
        check("t1_dropped_rsp", 64'(res_q.size() - nres), 64'd1);
        check("t1_result", 64'(res_q[$]), 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
